dds_multi: RTL and testbench
============================

Name: dds_multi

Overview:
Parametrised multi-channel DDS tone generator; next generation of the single-channel note-to-tuning-word phase accumulator.
- Each channel selects a note from a shared, runtime-writable tuning-word table.
- Optional glide (portamento) walks the channel's tuning word toward its target.
- Each channel outputs a square divided clock, a selectable waveform sample and a wrap pulse; feeds the audio mixer/PWM stage.

Parameters:
ACC_W, 32, phase accumulator and tuning word width
NCH, 2, number of independent channels
NOTE_W, 3, note index width; table depth 2**NOTE_W
OUT_W, 8, waveform sample width (OUT_W <= ACC_W-1)
GLIDE_SHIFT, 4, glide step = (target-current) >>> GLIDE_SHIFT
GLIDE_DIV, 1024, clk cycles per glide tick (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
note_bin  in  NCH*NOTE_W  per-channel note index, channel c at [c*NOTE_W +: NOTE_W]
glide_en  in  NCH  per-channel glide enable
wave_mode  in  NCH*2  per-channel waveform select
tbl_we  in  1  table write strobe
tbl_addr  in  NOTE_W  table write address
tbl_data  in  ACC_W  table write data
divide_clk  out  NCH  registered accumulator MSB per channel
wave  out  NCH*OUT_W  registered waveform sample per channel
wrap_pulse  out  NCH  1-cycle pulse on accumulator carry-out

Behaviour:
- Single clock, reset synchronous and active-high (rst sampled on clk rising edge).
- Reset: all accumulators 0, current tuning words 0, glide prescaler 0, divide_clk/wave/wrap_pulse 0. Table reloads defaults: entry0=0; entries 1..7 = 561824, 630651, 707875, 749965, 841792, 944892, 1060599. Entries beyond 7 are 0.
- Reset mid-operation aborts glides and discards runtime table writes.
- Table: combinational read per channel: target_k[c] = table[note_bin[c]].
- tbl_we writes on the clock edge.
- Same-cycle write and read of one entry: read returns the old value; the new value is seen from the next cycle.
- Accumulator: acc[c] <= acc[c] + cur_k[c], modulo 2**ACC_W.
- carry[c] = carry-out of that add; wrap_pulse[c] <= carry[c].
- Outputs register from the pre-update acc, one cycle behind it: divide_clk[c] <= acc[c][ACC_W-1]. wave is computed from the same acc value.
- wave_mode:
  - 0 square: all bits = MSB.
  - 1 saw: acc[ACC_W-1 -: OUT_W].
  - 2 triangle: acc[ACC_W-2 -: OUT_W] XOR {OUT_W{MSB}}.
  - 3 silence: 0.
- Note 0 (target 0) forces cur_k=0 immediately, with no glide. The accumulator clears to 0 on the next edge and holds there.
- Glide prescaler: a shared counter 0..GLIDE_DIV-1. glide_tick asserts for one cycle when the counter is GLIDE_DIV-1, then the counter wraps to 0.
- Per-channel glide FSM:
  - IDLE (cur_k==target_k) -> GLIDE when target_k differs and glide_en=1 and target_k!=0.
  - glide_en=0: cur_k <= target_k on the next edge; state stays IDLE.
  - GLIDE, on glide_tick: d = target_k - cur_k, signed ACC_W+1.
    - If |d| < 2**GLIDE_SHIFT: cur_k <= target_k, go to IDLE.
    - Otherwise: cur_k <= cur_k + (d >>> GLIDE_SHIFT).
  - GLIDE, target change (note change or table write): retarget from the present cur_k; no restart. Dropping glide_en in GLIDE snaps cur_k to target and returns to IDLE.
- Channels are fully independent except for the shared table and prescaler.

Decomposition:
- Package dds_pkg: default tuning-word constants (DEF_K array), wave_mode enum (WM_SQUARE, WM_SAW, WM_TRI, WM_OFF), glide state enum (GL_IDLE, GL_GLIDE).
- Sub-module dds_channel: accumulator, glide FSM, waveform mux and output registers. Instantiated NCH times.
- Top level holds the table, write port and glide prescaler.

Test Plan:
- Defaults, reset, ch0 note 1, glide off, mode 0 -> acc steps 561824/cycle; divide_clk[0] first rises 1 cycle after acc reaches >=2**31 (3823rd increment); first wrap_pulse after the 7645th increment, width 1 cycle.
- ch0 note 0 after running -> acc 0 on next edge; divide_clk=0, wave=0, no wrap_pulse thereafter.
- GLIDE_SHIFT=4, GLIDE_DIV=1, glide on, ch1 from note 1 to 7 -> first tick cur_k = 561824+(498775>>>4)=592997; monotonic approach; cur_k==1060599 and IDLE within ~200 ticks; no overshoot.
- tbl_we addr 3 data 0x01000000 while ch0 plays note 3 -> old word used that cycle, 0x01000000 from next cycle; wrap_pulse every 256 cycles.
- Mode sweep at acc=0xC0000000, OUT_W=8 -> square 0xFF, saw 0xC0, triangle 0x7F, off 0x00.
- Assert rst mid-glide on both channels -> all outputs 0 next cycle; table entry 3 back to 707875.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and default tuning words for the multi-channel DDS tone generator.
package dds_pkg;

    localparam int unsigned DEF_N = 8;

    localparam logic [31:0] DEF_K [DEF_N] = '{
        32'd0,      32'd561824, 32'd630651, 32'd707875,
        32'd749965, 32'd841792, 32'd944892, 32'd1060599
    };

    typedef enum logic [1:0] {
        WM_SQUARE = 2'd0,
        WM_SAW    = 2'd1,
        WM_TRI    = 2'd2,
        WM_OFF    = 2'd3
    } wave_mode_e;

    typedef enum logic {
        GL_IDLE  = 1'b0,
        GL_GLIDE = 1'b1
    } glide_state_e;

    // Entries past the built-in note set reset to silence.
    function automatic logic [31:0] def_k(input int unsigned idx);
        logic [2:0] sel;
        sel = idx[2:0];
        return (idx < DEF_N) ? DEF_K[sel] : 32'd0;
    endfunction

endpackage

// File: rtl/dds_channel.sv
// One DDS voice: phase accumulator, portamento FSM and registered waveform outputs.
module dds_channel
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned OUT_W       = 8,
    parameter int unsigned GLIDE_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] target_k,
    input  logic             glide_en,
    input  logic [1:0]       wave_mode,
    input  logic             glide_tick,
    output logic             divide_clk,
    output logic [OUT_W-1:0] wave,
    output logic             wrap_pulse
);

    localparam logic [ACC_W:0] SNAP_LIM = (ACC_W+1)'(1) << GLIDE_SHIFT;

    glide_state_e            state_q, state_d;
    logic [ACC_W-1:0]        cur_k_q, cur_k_d;
    logic [ACC_W-1:0]        acc_q, acc_d, acc_sum;
    logic                    carry, kill, snap;
    logic signed [ACC_W:0]   diff, step;
    logic [ACC_W:0]          mag;
    logic [OUT_W-1:0]        wave_d;
    logic                    msb;

    // Note 0 silences the voice outright, bypassing any glide.
    assign kill = (target_k == '0);

    assign diff = $signed({1'b0, target_k}) - $signed({1'b0, cur_k_q});
    assign mag  = diff[ACC_W] ? $unsigned(-diff) : $unsigned(diff);
    assign snap = (mag < SNAP_LIM);
    assign step = diff >>> GLIDE_SHIFT;

    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, cur_k_q};
    assign acc_d = kill ? '0 : acc_sum;
    assign msb   = acc_q[ACC_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GL_IDLE;
            cur_k_q <= '0;
        end else begin
            state_q <= state_d;
            cur_k_q <= cur_k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GL_IDLE: begin
                if ((target_k != cur_k_q) && glide_en && !kill) state_d = GL_GLIDE;
            end
            GL_GLIDE: begin
                if (kill || !glide_en || (glide_tick && snap)) state_d = GL_IDLE;
            end
            default: state_d = GL_IDLE;
        endcase
    end

    always_comb begin
        cur_k_d = cur_k_q;
        if (kill) begin
            cur_k_d = '0;
        end else begin
            case (state_q)
                GL_IDLE: begin
                    if (!glide_en) cur_k_d = target_k;
                end
                GL_GLIDE: begin
                    if (!glide_en || (glide_tick && snap)) cur_k_d = target_k;
                    else if (glide_tick) cur_k_d = cur_k_q + ACC_W'(step);
                end
                default: cur_k_d = target_k;
            endcase
        end
    end

    always_comb begin
        wave_d = '0;
        case (wave_mode_e'(wave_mode))
            WM_SQUARE: wave_d = {OUT_W{msb}};
            WM_SAW:    wave_d = acc_q[ACC_W-1 -: OUT_W];
            WM_TRI:    wave_d = acc_q[ACC_W-2 -: OUT_W] ^ {OUT_W{msb}};
            default:   wave_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            divide_clk <= 1'b0;
            wave       <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            divide_clk <= msb;
            wave       <= wave_d;
            wrap_pulse <= carry & ~kill;
        end
    end

endmodule

// File: rtl/dds_multi.sv
// Multi-channel DDS top: shared runtime-writable tuning table, glide prescaler and NCH voices.
module dds_multi
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned NCH         = 2,
    parameter int unsigned NOTE_W      = 3,
    parameter int unsigned OUT_W       = 8,
    parameter int unsigned GLIDE_SHIFT = 4,
    parameter int unsigned GLIDE_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*NOTE_W-1:0] note_bin,
    input  logic [NCH-1:0]        glide_en,
    input  logic [NCH*2-1:0]      wave_mode,
    input  logic                  tbl_we,
    input  logic [NOTE_W-1:0]     tbl_addr,
    input  logic [ACC_W-1:0]      tbl_data,
    output logic [NCH-1:0]        divide_clk,
    output logic [NCH*OUT_W-1:0]  wave,
    output logic [NCH-1:0]        wrap_pulse
);

    localparam int unsigned DEPTH = 2 ** NOTE_W;
    localparam int unsigned PW    = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;

    logic [ACC_W-1:0] tbl_q [DEPTH];
    logic [PW-1:0]    presc_q;
    logic             glide_tick;

    // Reads see the pre-write contents; a write lands on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= ACC_W'(def_k(i));
            end
        end else if (tbl_we) begin
            tbl_q[tbl_addr] <= tbl_data;
        end
    end

    assign glide_tick = (presc_q == PW'(GLIDE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || glide_tick) presc_q <= '0;
        else                   presc_q <= presc_q + 1'b1;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [ACC_W-1:0] target_k;

        assign target_k = tbl_q[note_bin[c*NOTE_W +: NOTE_W]];

        dds_channel #(
            .ACC_W      (ACC_W),
            .OUT_W      (OUT_W),
            .GLIDE_SHIFT(GLIDE_SHIFT)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .target_k  (target_k),
            .glide_en  (glide_en[c]),
            .wave_mode (wave_mode[c*2 +: 2]),
            .glide_tick(glide_tick),
            .divide_clk(divide_clk[c]),
            .wave      (wave[c*OUT_W +: OUT_W]),
            .wrap_pulse(wrap_pulse[c])
        );
    end

endmodule

// File: tb/tb_dds_multi.sv
// Directed bench for dds_multi: tone timing, note-0 mute, glide, table write, wave modes, reset.
module tb_dds_multi;
    import dds_pkg::*;

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned NCH    = 2;
    localparam int unsigned NOTE_W = 3;
    localparam int unsigned OUT_W  = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH*NOTE_W-1:0] note_bin;
    logic [NCH-1:0]        glide_en;
    logic [NCH*2-1:0]      wave_mode;
    logic                  tbl_we;
    logic [NOTE_W-1:0]     tbl_addr;
    logic [ACC_W-1:0]      tbl_data;
    logic [NCH-1:0]        divide_clk;
    logic [NCH*OUT_W-1:0]  wave;
    logic [NCH-1:0]        wrap_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dds_multi #(
        .ACC_W      (ACC_W),
        .NCH        (NCH),
        .NOTE_W     (NOTE_W),
        .OUT_W      (OUT_W),
        .GLIDE_SHIFT(4),
        .GLIDE_DIV  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .note_bin  (note_bin),
        .glide_en  (glide_en),
        .wave_mode (wave_mode),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .divide_clk(divide_clk),
        .wave      (wave),
        .wrap_pulse(wrap_pulse)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int first_div, first_wrap, gap, cnt, bad, done, found;
        logic [ACC_W-1:0] prev_k, k;
        logic [7:0] exp_w [4];
        exp_w = '{8'hFF, 8'hC0, 8'h7F, 8'h00};

        rst = 1'b1; note_bin = '0; glide_en = '0; wave_mode = '0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        repeat (3) @(negedge clk);
        check("rst_div", 64'(divide_clk), 64'd0);
        check("rst_wave", 64'(wave), 64'd0);
        check("rst_wrap", 64'(wrap_pulse), 64'd0);
        check("rst_tbl7", 64'(dut.tbl_q[7]), 64'd1060599);

        // ch0 note 1, square, no glide
        rst = 1'b0;
        note_bin[2:0] = 3'd1;
        first_div = 0; first_wrap = 0;
        for (int i = 1; i <= 7700 && first_wrap == 0; i++) begin
            @(negedge clk);
            if (first_div == 0 && divide_clk[0]) begin
                first_div = i;
                check("sq_wave_hi", 64'(wave[7:0]), 64'hFF);
            end
            if (wrap_pulse[0]) first_wrap = i;
        end
        check("first_div", 64'(first_div), 64'd3825);
        check("first_wrap", 64'(first_wrap), 64'd7646);
        @(negedge clk);
        check("wrap_width", 64'(wrap_pulse[0]), 64'd0);

        // note 0 mutes
        note_bin[2:0] = 3'd0;
        @(negedge clk);
        check("note0_acc", 64'(dut.g_ch[0].u_ch.acc_q), 64'd0);
        check("note0_curk", 64'(dut.g_ch[0].u_ch.cur_k_q), 64'd0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (divide_clk[0] || wave[7:0] != 8'd0 || wrap_pulse[0]) bad++;
        end
        check("note0_quiet", 64'(bad), 64'd0);

        // ch1 glide from note 1 to note 7
        note_bin[5:3] = 3'd1;
        repeat (2) @(negedge clk);
        check("gl_start_k", 64'(dut.g_ch[1].u_ch.cur_k_q), 64'd561824);
        glide_en[1] = 1'b1;
        note_bin[5:3] = 3'd7;
        @(negedge clk);
        check("gl_enter", 64'(dut.g_ch[1].u_ch.state_q), 64'(GL_GLIDE));
        check("gl_hold_k", 64'(dut.g_ch[1].u_ch.cur_k_q), 64'd561824);
        @(negedge clk);
        check("gl_first_step", 64'(dut.g_ch[1].u_ch.cur_k_q), 64'd592997);
        prev_k = 32'd592997; bad = 0; cnt = 1; done = 0;
        for (int i = 0; i < 400 && done == 0; i++) begin
            @(negedge clk);
            k = dut.g_ch[1].u_ch.cur_k_q;
            if (k < prev_k || k > 32'd1060599) bad++;
            prev_k = k;
            cnt++;
            if (dut.g_ch[1].u_ch.state_q == GL_IDLE) done = 1;
        end
        check("gl_monotonic", 64'(bad), 64'd0);
        check("gl_done", 64'(done), 64'd1);
        check("gl_final", 64'(prev_k), 64'd1060599);
        check("gl_ticks", 64'(cnt <= 200), 64'd1);

        // table write while ch0 plays note 3
        note_bin[2:0] = 3'd3;
        repeat (2) @(negedge clk);
        check("tw_old_k", 64'(dut.g_ch[0].u_ch.cur_k_q), 64'd707875);
        tbl_we = 1'b1; tbl_addr = 3'd3; tbl_data = 32'h0100_0000;
        @(negedge clk);
        tbl_we = 1'b0;
        check("tw_same_cycle", 64'(dut.g_ch[0].u_ch.cur_k_q), 64'd707875);
        check("tw_table", 64'(dut.tbl_q[3]), 64'h0100_0000);
        @(negedge clk);
        check("tw_next_cycle", 64'(dut.g_ch[0].u_ch.cur_k_q), 64'h0100_0000);

        // realign acc to 0, then measure wrap period
        note_bin[2:0] = 3'd0;
        repeat (2) @(negedge clk);
        note_bin[2:0] = 3'd3;
        first_wrap = 0; gap = 0;
        for (int i = 1; i <= 600 && first_wrap == 0; i++) begin
            @(negedge clk);
            if (wrap_pulse[0]) first_wrap = i;
        end
        for (int i = 1; i <= 600 && gap == 0; i++) begin
            @(negedge clk);
            if (wrap_pulse[0]) gap = i;
        end
        check("wrap_first", 64'(first_wrap), 64'd257);
        check("wrap_period", 64'(gap), 64'd256);

        // wave mode sweep with acc = 0xC0000000
        for (int m = 0; m < 4; m++) begin
            found = 0;
            for (int i = 0; i < 300 && found == 0; i++) begin
                @(negedge clk);
                if (dut.g_ch[0].u_ch.acc_q == 32'hC000_0000) found = 1;
            end
            check($sformatf("sweep_found%0d", m), 64'(found), 64'd1);
            wave_mode[1:0] = m[1:0];
            @(negedge clk);
            check($sformatf("wave_mode%0d", m), 64'(wave[7:0]), 64'(exp_w[m]));
        end
        wave_mode = '0;

        // reset in the middle of glides on both channels
        glide_en = 2'b11;
        note_bin[2:0] = 3'd5;
        note_bin[5:3] = 3'd1;
        repeat (2) @(negedge clk);
        check("rg_ch0_glide", 64'(dut.g_ch[0].u_ch.state_q), 64'(GL_GLIDE));
        check("rg_ch1_glide", 64'(dut.g_ch[1].u_ch.state_q), 64'(GL_GLIDE));
        rst = 1'b1;
        @(negedge clk);
        check("rg_div", 64'(divide_clk), 64'd0);
        check("rg_wave", 64'(wave), 64'd0);
        check("rg_wrap", 64'(wrap_pulse), 64'd0);
        check("rg_tbl3", 64'(dut.tbl_q[3]), 64'd707875);
        check("rg_ch0_idle", 64'(dut.g_ch[0].u_ch.state_q), 64'(GL_IDLE));
        check("rg_ch1_curk", 64'(dut.g_ch[1].u_ch.cur_k_q), 64'd0);
        rst = 1'b0; note_bin = '0; glide_en = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
